uart_cmd_master: RTL and testbench

- Initiator that drives the word-level read/write request interface of the UART bridge.
- Reads 32-bit command words arriving from the host over UART and decodes them.
- Executes each command as a single memory-bus read or write, then sends one 32-bit reply word back through the bridge.
- Sits between the UART bridge and the controller's memory/debug bus, giving the host remote load/peek access.

---
 rtl/uart_cmd_master.sv | 102 ++++++++++
 tb/tb_uart_cmd_master.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: fetches 32-bit host commands over the UART bridge, runs one memory access, replies with one word
module uart_cmd_master #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] PING_WORD      = 32'h50494E47
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx_empty,
    output logic        uart_read,
    input  logic        uart_read_response,
    input  logic [31:0] uart_read_data,
    output logic        uart_write,
    output logic [31:0] uart_write_data,
    input  logic        uart_write_response,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ack,
    output logic        busy,
    output logic        error
);
    localparam int          TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  OP_WRITE = 8'h01;
    localparam logic [7:0]  OP_READ  = 8'h02;
    localparam logic [7:0]  OP_PING  = 8'h03;

    typedef enum logic [3:0] {
        IDLE, CMD_REQ, CMD_WAIT, CMD_GUARD, DECODE,
        DATA_REQ, DATA_WAIT, DATA_GUARD, MEM,
        RESP_REQ, RESP_WAIT, RESP_GUARD
    } state_t;

    state_t         state, state_next;
    logic [31:0]    cmd, data;
    logic [TW-1:0]  timer;
    logic [7:0]     op;
    logic           expired;

    assign op             = cmd[31:24];
    assign expired        = (state == MEM) && !mem_ack && (timer == T_LAST);
    assign mem_address    = {6'b0, cmd[23:0], 2'b00};
    assign mem_write_data = data;

    // State register; reset returns to IDLE immediately, even mid-transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and request outputs; requests are pure functions of state so reset drops them at once
    always_comb begin
        state_next = state;
        uart_read  = (state == CMD_REQ) || (state == DATA_REQ);
        uart_write = (state == RESP_REQ);
        mem_read   = (state == MEM) && (op == OP_READ);
        mem_write  = (state == MEM) && (op == OP_WRITE);
        busy       = (state != IDLE);
        case (state)
            IDLE:       state_next = uart_rx_empty ? IDLE : CMD_REQ;
            CMD_REQ:    state_next = CMD_WAIT;
            CMD_WAIT:   state_next = uart_read_response ? CMD_GUARD : CMD_WAIT;
            CMD_GUARD:  state_next = uart_read_response ? CMD_GUARD : DECODE;
            DECODE:     state_next = (op == OP_WRITE) ? DATA_REQ : (op == OP_READ) ? MEM : RESP_REQ;
            DATA_REQ:   state_next = DATA_WAIT;
            DATA_WAIT:  state_next = uart_read_response ? DATA_GUARD : DATA_WAIT;
            DATA_GUARD: state_next = uart_read_response ? DATA_GUARD : MEM;
            MEM:        state_next = (mem_ack || expired) ? RESP_REQ : MEM;
            RESP_REQ:   state_next = RESP_WAIT;
            RESP_WAIT:  state_next = uart_write_response ? RESP_GUARD : RESP_WAIT;
            RESP_GUARD: state_next = uart_write_response ? RESP_GUARD : IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Datapath: capture words on the first response cycle, load the reply before RESP_REQ, count MEM cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd             <= '0;
            data            <= '0;
            timer           <= '0;
            uart_write_data <= '0;
            error           <= 1'b0;
        end else begin
            timer <= (state == MEM && state_next == MEM) ? timer + 1'b1 : '0;
            if (state == CMD_WAIT && uart_read_response)
                cmd <= uart_read_data;
            if (state == DATA_WAIT && uart_read_response)
                data <= uart_read_data;
            if (state == DECODE && op != OP_WRITE && op != OP_READ)
                uart_write_data <= (op == OP_PING) ? PING_WORD : 32'hFFFFFFFF;
            if (state == MEM && mem_ack)
                uart_write_data <= (op == OP_WRITE) ? 32'h00000001 : mem_read_data;
            if (expired) begin
                uart_write_data <= 32'hDEADDEAD;
                error           <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: directed checks of uart_cmd_master against bridge and memory models
module tb_uart_cmd_master;
    logic        clk, reset;
    logic        uart_rx_empty, uart_read, uart_read_response;
    logic [31:0] uart_read_data;
    logic        uart_write, uart_write_response;
    logic [31:0] uart_write_data;
    logic        mem_read, mem_write, mem_ack;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        busy, error;

    uart_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .uart_rx_empty(uart_rx_empty), .uart_read(uart_read),
        .uart_read_response(uart_read_response), .uart_read_data(uart_read_data),
        .uart_write(uart_write), .uart_write_data(uart_write_data),
        .uart_write_response(uart_write_response),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .mem_ack(mem_ack), .busy(busy), .error(error)
    );

    int vectors = 0, miscompares = 0;
    logic [31:0] rx_q[$];
    int rd_pulses = 0, wr_pulses = 0, rd_cyc = 0, wr_cyc = 0;
    int both_err = 0, excl_err = 0, stab_err = 0, tx_cnt = 0;
    logic [31:0] tx_word = 0, last_addr = 0, last_wdata = 0;
    int ack_delay = 0;
    logic [31:0] rd_val = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Protocol monitor
    always @(negedge clk) begin
        if (uart_read) rd_pulses++;
        if (uart_write) wr_pulses++;
        if (uart_read && uart_write) both_err++;
        if (mem_read && mem_write) excl_err++;
        if (mem_read) rd_cyc++;
        if (mem_write) wr_cyc++;
        if (mem_read || mem_write) begin
            last_addr = mem_address;
            if (mem_write) last_wdata = mem_write_data;
        end
    end

    // Bridge read side: response one cycle after request, held 2 cycles
    initial begin
        uart_read_response = 0;
        uart_read_data = 0;
        uart_rx_empty = 1;
        forever begin
            @(negedge clk);
            uart_rx_empty = (rx_q.size() == 0);
            if (uart_read) begin
                @(negedge clk);
                uart_read_data = (rx_q.size() != 0) ? rx_q.pop_front() : 32'h0;
                uart_read_response = 1;
                @(negedge clk);
                @(negedge clk);
                uart_read_response = 0;
                uart_rx_empty = (rx_q.size() == 0);
            end
        end
    end

    // Bridge write side: records the reply and checks it stays stable through the response
    initial begin
        uart_write_response = 0;
        forever begin
            @(negedge clk);
            if (uart_write) begin
                tx_word = uart_write_data;
                tx_cnt++;
                @(negedge clk);
                if (uart_write_data !== tx_word) stab_err++;
                uart_write_response = 1;
                @(negedge clk);
                @(negedge clk);
                if (uart_write_data !== tx_word) stab_err++;
                uart_write_response = 0;
            end
        end
    end

    // Memory: acks after ack_delay request cycles; negative delay never acks
    initial begin
        int cyc;
        cyc = 0;
        mem_ack = 0;
        mem_read_data = 0;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                mem_ack = (ack_delay >= 0 && cyc == ack_delay);
                mem_read_data = mem_ack ? rd_val : 32'h0;
                cyc++;
            end else begin
                mem_ack = 0;
                cyc = 0;
            end
        end
    end

    int b_rd, b_rdc, b_wrc, b_tx;

    task automatic transact(input logic [31:0] w0, input logic [31:0] w1, input int nw);
        int n;
        n = 0;
        b_rd = rd_pulses; b_rdc = rd_cyc; b_wrc = wr_cyc; b_tx = tx_cnt;
        rx_q.push_back(w0);
        if (nw == 2) rx_q.push_back(w1);
        while (!(tx_cnt != b_tx && !busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("complete", 32'(n < 1000), 32'd1);
    endtask

    initial begin
        int n;
        reset = 1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(error), 0);
        chk("rst_req", {28'd0, uart_read, uart_write, mem_read, mem_write}, 0);
        chk("rst_wdata", uart_write_data, 0);
        chk("rst_addr", mem_address, 0);
        reset = 0;
        @(negedge clk);

        transact(32'h03000000, 0, 1);
        chk("ping_reply", tx_word, 32'h50494E47);
        chk("ping_wr_pulses", 32'(tx_cnt - b_tx), 1);
        chk("ping_rd_pulses", 32'(rd_pulses - b_rd), 1);
        chk("ping_mem", 32'((rd_cyc - b_rdc) + (wr_cyc - b_wrc)), 0);
        chk("ping_err", 32'(error), 0);

        ack_delay = 3;
        transact(32'h01000010, 32'hCAFEBABE, 2);
        chk("wr_rd_pulses", 32'(rd_pulses - b_rd), 2);
        chk("wr_cycles", 32'(wr_cyc - b_wrc), 4);
        chk("wr_no_read", 32'(rd_cyc - b_rdc), 0);
        chk("wr_addr", last_addr, 32'h00000040);
        chk("wr_data", last_wdata, 32'hCAFEBABE);
        chk("wr_reply", tx_word, 32'h00000001);

        ack_delay = 0;
        rd_val = 32'h12345678;
        transact(32'h02000010, 0, 1);
        chk("rd_cycles", 32'(rd_cyc - b_rdc), 1);
        chk("rd_no_write", 32'(wr_cyc - b_wrc), 0);
        chk("rd_addr", last_addr, 32'h00000040);
        chk("rd_reply", tx_word, 32'h12345678);
        chk("rd_rd_pulses", 32'(rd_pulses - b_rd), 1);

        transact(32'h7F000000, 0, 1);
        chk("bad_mem", 32'((rd_cyc - b_rdc) + (wr_cyc - b_wrc)), 0);
        chk("bad_reply", tx_word, 32'hFFFFFFFF);
        chk("bad_err", 32'(error), 0);

        ack_delay = -1;
        transact(32'h02000123, 0, 1);
        chk("to_cycles", 32'(rd_cyc - b_rdc), 16);
        chk("to_addr", last_addr, 32'h0000048C);
        chk("to_reply", tx_word, 32'hDEADDEAD);
        chk("to_err", 32'(error), 1);

        transact(32'h03000000, 0, 1);
        chk("ping2_reply", tx_word, 32'h50494E47);
        chk("ping2_err_sticky", 32'(error), 1);

        rx_q.push_back(32'h02000020);
        n = 0;
        while (!mem_read && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_mem_reached", 32'(mem_read), 1);
        repeat (3) @(negedge clk);
        reset = 1;
        #1;
        chk("mid_rst_req", {28'd0, uart_read, uart_write, mem_read, mem_write}, 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_err", 32'(error), 0);
        chk("mid_rst_wdata", uart_write_data, 0);
        chk("mid_rst_addr", mem_address, 0);
        @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 0);

        chk("rd_wr_overlap", 32'(both_err), 0);
        chk("mem_excl", 32'(excl_err), 0);
        chk("wdata_stable", 32'(stab_err), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
